// File: rtl/mdr_mem_if.sv
// ============================================================================
// Module      : mdr_mem_if
// Description : Memory data register with a req/ack memory handshake engine.
//               Supports byte/half/word/full accesses with lane steering on
//               writes, lane extraction plus zero/sign extension on reads,
//               and busy/done/err status for the control unit.
//               Optional feature macro: MDR_TIMEOUT_EN (abort a transaction
//               that sees no mem_ack within TIMEOUT request cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdr_mem_if #(
    parameter int DATA_W  = 32,
    parameter int OFF_W   = 3,
    parameter int TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     BusMuxOut,
    input  logic                  MDRin,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [OFF_W-1:0]      byte_off,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic [DATA_W-1:0]     Q,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int NB = DATA_W / 8;     // bytes per memory word
    localparam int LB = $clog2(NB);     // byte-offset bits actually used

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      size_lat;
    logic            sext_lat;
    logic [LB-1:0]   off_lat;

    // Only the low LB offset bits select a lane; upper bits are don't-care.
    logic [LB-1:0]   off_lo;
    assign off_lo = byte_off[LB-1:0];

    // Right-justified data mask covering the bytes of one access.
    function automatic logic [DATA_W-1:0] lane_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    lane_mask = DATA_W'(8'hFF);
            2'd1:    lane_mask = DATA_W'(16'hFFFF);
            2'd2:    lane_mask = DATA_W'(32'hFFFF_FFFF);
            default: lane_mask = '1;
        endcase
    endfunction

    // Byte-enable pattern of one access before shifting to its offset.
    function automatic logic [NB-1:0] be_base(input logic [1:0] sz);
        case (sz)
            2'd0:    be_base = NB'(1'b1);
            2'd1:    be_base = NB'(2'b11);
            2'd2:    be_base = NB'(4'hF);
            default: be_base = '1;
        endcase
    endfunction

    // Alignment: offset must be a multiple of the access size in bytes.
    logic aligned;
    always_comb begin
        aligned = 1'b1;
        case (size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = (off_lo[0] == 1'b0);
            2'd2:    aligned = (off_lo[1:0] == 2'b00);
            default: aligned = (off_lo == '0);
        endcase
    end

    // Start-edge values: lane-steered write data and shifted byte enables.
    logic [DATA_W-1:0] wr_steered;
    logic [NB-1:0]     be_start;
    assign wr_steered = (Q & lane_mask(size)) << {off_lo, 3'b000};
    assign be_start   = be_base(size) << off_lo;

    // Read path: bring the addressed lanes down to bit 0, then extend.
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] rd_mask;
    logic              rd_msb;
    logic [DATA_W-1:0] rd_ext;
    assign rd_shift = mem_rdata >> {off_lat, 3'b000};
    assign rd_mask  = lane_mask(size_lat);

    // Pick the sign bit of the latched access size; full-width never extends.
    always_comb begin
        rd_msb = 1'b0;
        case (size_lat)
            2'd0:    rd_msb = rd_shift[7];
            2'd1:    rd_msb = rd_shift[15];
            2'd2:    rd_msb = rd_shift[31];
            default: rd_msb = 1'b0;
        endcase
    end

    assign rd_ext = (rd_shift & rd_mask) |
                    ((sext_lat && rd_msb) ? ~rd_mask : '0);

`ifdef MDR_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt;
`endif

    // Offset bits above LB are intentionally ignored; TIMEOUT is idle when
    // the abort counter is not built.
    logic unused_ok;
    assign unused_ok = (^{1'b0, byte_off}) ^ (TIMEOUT == 0);

    // Handshake FSM; every output is registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            size_lat  <= 2'd0;
            sext_lat  <= 1'b0;
            off_lat   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_wdata <= '0;
            Q         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef MDR_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_rd || mem_wr) begin
                        // A start always swallows a coincident MDRin.
                        if (aligned) begin
                            state     <= mem_rd ? RD : WR;
                            size_lat  <= size;
                            sext_lat  <= sign_ext;
                            off_lat   <= off_lo;
                            mem_req   <= 1'b1;
                            mem_we    <= ~mem_rd;
                            mem_be    <= be_start;
                            mem_wdata <= mem_rd ? '0 : wr_steered;
                            busy      <= 1'b1;
`ifdef MDR_TIMEOUT_EN
                            to_cnt    <= '0;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (MDRin) begin
                        Q <= BusMuxOut;
                    end
                end
                RD, WR: begin
                    if (mem_ack) begin
                        // Completion takes precedence over a same-cycle timeout.
                        if (state == RD) begin
                            Q <= rd_ext;
                        end
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
`ifdef MDR_TIMEOUT_EN
                    else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_wdata <= '0;
                        busy      <= 1'b0;
                        err       <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/mdr_mem_if.md
Name: mdr_mem_if

Overview:
Parametrised memory data register with a built-in memory handshake engine. It replaces the plain mux-plus-register MDR with four functions:
- a DATA_W-wide register
- a req/ack memory port
- byte/half/word/full sizing with lane extraction and sign extension
- busy/done status for the control unit

It sits between the internal bus (BusMuxOut) and the memory subsystem.

Parameters:
DATA_W, 32, register and memory data width; multiple of 32 (32 or 64 supported).
OFF_W, 3, byte-offset width; must be at least log2(DATA_W/8). Only the low log2(DATA_W/8) bits are used.
TIMEOUT, 15, cycles to wait for mem_ack before abort; used only with MDR_TIMEOUT_EN.

Ports:
clock  in  1  single clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
BusMuxOut  in  DATA_W  internal bus data.
MDRin  in  1  load Q from BusMuxOut (full width).
mem_rd  in  1  start a memory read into Q.
mem_wr  in  1  start a memory write of Q.
size  in  2  access size: 0 byte, 1 half, 2 word (32b), 3 full DATA_W.
sign_ext  in  1  sign-extend read data (size 0/1/2 only).
byte_off  in  OFF_W  byte offset of the access within the memory word.
mem_req  out  1  memory request.
mem_we  out  1  1 write, 0 read; valid while mem_req=1.
mem_be  out  DATA_W/8  byte enables for the access.
mem_wdata  out  DATA_W  write data, shifted to the addressed lanes.
mem_rdata  in  DATA_W  read data; sampled on the mem_ack cycle.
mem_ack  in  1  memory completion, one-cycle pulse.
Q  out  DATA_W  MDR contents.
busy  out  1  transaction in progress.
done  out  1  one-cycle pulse after transaction completes.
err  out  1  one-cycle pulse on misaligned request or timeout.

Behaviour:
- Reset values: Q=0, mem_req=0, mem_we=0, mem_be=0, mem_wdata=0, busy=0, done=0, err=0; state=IDLE. Reset mid-transaction aborts immediately; no done pulse is issued.
- States: IDLE, RD, WR.
- IDLE priority: mem_rd > mem_wr > MDRin.
  - mem_rd → RD; mem_wr → WR.
  - MDRin alone → Q<=BusMuxOut next edge, state stays IDLE.
  - MDRin coincident with a start is dropped.
- Alignment: byte_off must be a multiple of the access bytes (1/2/4/DATA_W/8). Misaligned start: no state change, no request, err=1 for one cycle, Q unchanged. size=3 requires byte_off=0.
- Start edge registers all of the following and holds them stable until ack:
  - size, sign_ext, byte_off
  - mem_req=1, mem_we (1 in WR, 0 in RD), busy=1
  - mem_be: contiguous ones at [byte_off +: nbytes]
  - WR only: mem_wdata = low nbytes of Q shifted left by 8*byte_off; unused lanes 0.
- RD/WR: wait for mem_ack. A sampled mem_ack means, at that edge:
  - mem_req=0, busy=0, mem_be=0, done=1 for the next cycle, return to IDLE.
  - RD only: Q <= lanes [byte_off +: nbytes] of mem_rdata, right-justified, upper bits zero- or sign-filled per sign_ext.
  - size=3: Q <= mem_rdata, sign_ext ignored.
- Minimum latency: start cycle, then request asserted, then ack in the same cycle as the first request cycle, then done. Start to done = 2 cycles when memory acks immediately.
- Inputs ignored while busy=1: MDRin, mem_rd, mem_wr, size, sign_ext, byte_off. Q is held.
- mem_ack while IDLE: ignored.
- done and err never assert in the same cycle.

Optional Feature:
MDR_TIMEOUT_EN:
- Defined: a counter clears on start and increments each cycle in RD/WR without ack. When it reaches TIMEOUT, the transaction aborts at that edge:
  - mem_req=0, busy=0, err=1 for one cycle, no done pulse, Q unchanged, state to IDLE.
  - An ack arriving in the same cycle as the timeout wins; the transaction completes normally.
- Not defined: waits indefinitely; err asserts only on misalignment; no counter is present.

Test Plan:
- Reset then MDRin=1 with BusMuxOut=0xDEADBEEF → Q=0xDEADBEEF next cycle; busy=0; mem_req never asserted.
- Read, size=0, sign_ext=1, byte_off=2; ack after 3 cycles with mem_rdata=0x1280FF34 → Q=0xFFFFFF80; mem_be=0b0100 throughout request; done pulses exactly once.
- Write, Q=0x0000ABCD, size=1, byte_off=2 → mem_we=1, mem_be=0b1100, mem_wdata=0xABCD0000 until ack; done next cycle.
- Misalignment: mem_rd with size=2, byte_off=1 → err pulse, mem_req stays 0, Q unchanged. Simultaneous mem_rd+MDRin, aligned → read executes and BusMuxOut is discarded.
- Reset asserted mid-RD before ack → next cycle all outputs 0, state IDLE, no done; a late mem_ack is ignored.
- MDR_TIMEOUT_EN, TIMEOUT=4, no ack → err pulses after 4 request cycles, busy=0, Q unchanged. Repeat with ack on the 4th cycle → done, no err.
